// File: rtl/proc_pkg.sv
// Shared pipeline-control types: the per-stage scoreboard entry used by the
// decode hazard logic.
package proc_pkg;

  // Entries carry a fixed-width rd so the type stays parameter-free; narrower
  // register addresses are zero-extended before comparison.
  localparam int HZ_RD_W = 8;

  typedef struct packed {
    logic               valid;
    logic [HZ_RD_W-1:0] rd;
    logic               wr_en;
    logic               is_load;
  } hz_entry_t;

endpackage

// File: rtl/hazard_match.sv
// Youngest-match priority encoder: finds the lowest-index in-flight entry that
// will write the given source register.
module hazard_match
  import proc_pkg::*;
#(
  parameter int DEPTH  = 3,
  parameter int REG_AW = 5,
  parameter int IDX_W  = $clog2(DEPTH)
) (
  input  hz_entry_t [DEPTH-1:0] entries,
  input  logic [REG_AW-1:0]     rs,
  input  logic                  rs_used,
  output logic                  hit,
  output logic [IDX_W-1:0]      idx,
  output logic                  is_load
);

  logic [HZ_RD_W-1:0] rs_ext;

  assign rs_ext = HZ_RD_W'(rs);

  // Scan oldest to youngest so the youngest match is the one left standing.
  always_comb begin
    hit     = 1'b0;
    idx     = '0;
    is_load = 1'b0;
    for (int k = DEPTH - 1; k >= 0; k--) begin
      if (entries[k].valid && entries[k].wr_en && (entries[k].rd == rs_ext) &&
          (rs != '0) && rs_used) begin
        hit     = 1'b1;
        idx     = IDX_W'(k);
        is_load = entries[k].is_load;
      end
    end
  end

endmodule

// File: rtl/hazard_ctrl_pipe.sv
// Decode-stage hazard control: tracks in-flight destinations and produces
// stall, kill and forwarding selects, plus a stall-cycle counter.
module hazard_ctrl_pipe
  import proc_pkg::*;
#(
  parameter int REG_AW         = 5,
  parameter int DEPTH          = 3,
  parameter int FWD_EN         = 0,
  parameter int LOAD_FWD_STAGE = 1,
  parameter int FETCH_SHADOW   = 1,
  parameter int SEL_W          = $clog2(DEPTH + 1)
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              d_valid_i,
  input  logic [REG_AW-1:0] d_rs1_i,
  input  logic              d_rs1_used_i,
  input  logic [REG_AW-1:0] d_rs2_i,
  input  logic              d_rs2_used_i,
  input  logic [REG_AW-1:0] d_rd_i,
  input  logic              d_wr_en_i,
  input  logic              d_is_load_i,
  input  logic              redirect_i,
  input  logic              mem_busy_i,
  output logic              issue_o,
  output logic              stall_o,
  output logic              kill_d_o,
  output logic [SEL_W-1:0]  fwd_rs1_sel_o,
  output logic [SEL_W-1:0]  fwd_rs2_sel_o,
  output logic [31:0]       stall_cnt_o
);

  localparam int IDX_W = $clog2(DEPTH);
  localparam logic [IDX_W-1:0] LOAD_STAGE_IDX = IDX_W'(LOAD_FWD_STAGE);
  localparam logic [2:0]       SHADOW_LOAD    = 3'(FETCH_SHADOW);

  hz_entry_t [DEPTH-1:0] entries;
  hz_entry_t             new_entry;
  logic [2:0]            shadow_cnt;

  logic             hit1, hit2, load1, load2;
  logic [IDX_W-1:0] idx1, idx2;
  logic             haz1, haz2;

  hazard_match #(.DEPTH(DEPTH), .REG_AW(REG_AW), .IDX_W(IDX_W)) u_match_rs1 (
    .entries (entries),
    .rs      (d_rs1_i),
    .rs_used (d_rs1_used_i),
    .hit     (hit1),
    .idx     (idx1),
    .is_load (load1)
  );

  hazard_match #(.DEPTH(DEPTH), .REG_AW(REG_AW), .IDX_W(IDX_W)) u_match_rs2 (
    .entries (entries),
    .rs      (d_rs2_i),
    .rs_used (d_rs2_used_i),
    .hit     (hit2),
    .idx     (idx2),
    .is_load (load2)
  );

  // With forwarding, only a load too young to have its data yet forces a stall.
  always_comb begin
    if (FWD_EN == 0) begin
      haz1 = hit1;
      haz2 = hit2;
    end else begin
      haz1 = hit1 && load1 && (idx1 < LOAD_STAGE_IDX);
      haz2 = hit2 && load2 && (idx2 < LOAD_STAGE_IDX);
    end
  end

  always_comb begin
    issue_o       = 1'b0;
    stall_o       = 1'b0;
    kill_d_o      = 1'b0;
    fwd_rs1_sel_o = '0;
    fwd_rs2_sel_o = '0;
    if (mem_busy_i) begin
      stall_o = 1'b1;
    end else if (redirect_i || (shadow_cnt != 3'd0)) begin
      kill_d_o = 1'b1;
    end else if (d_valid_i && (haz1 || haz2)) begin
      stall_o = 1'b1;
    end else begin
      issue_o = d_valid_i;
      if ((FWD_EN != 0) && d_valid_i) begin
        if (hit1) fwd_rs1_sel_o = SEL_W'(idx1) + SEL_W'(1);
        if (hit2) fwd_rs2_sel_o = SEL_W'(idx2) + SEL_W'(1);
      end
    end
  end

  always_comb begin
    new_entry         = '0;
    new_entry.valid   = 1'b1;
    new_entry.rd      = HZ_RD_W'(d_rd_i);
    new_entry.wr_en   = d_wr_en_i;
    new_entry.is_load = d_is_load_i;
  end

  // A memory freeze holds the scoreboard and shadow counter, but the stall
  // counter still advances.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      entries     <= '0;
      shadow_cnt  <= '0;
      stall_cnt_o <= '0;
    end else begin
      if (stall_o) stall_cnt_o <= stall_cnt_o + 32'd1;
      if (!mem_busy_i) begin
        for (int k = 1; k < DEPTH; k++) entries[k] <= entries[k-1];
        entries[0] <= issue_o ? new_entry : '0;
        if (redirect_i)              shadow_cnt <= SHADOW_LOAD;
        else if (shadow_cnt != 3'd0) shadow_cnt <= shadow_cnt - 3'd1;
      end
    end
  end

endmodule
